// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, word/lane
// geometry and the address error decode.
package dm_pkg;

  localparam int WORD_W = 32;
  localparam int LANE_W = 8;
  localparam int LANES  = WORD_W / LANE_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_RANGE
  } err_t;

  // Misalignment takes precedence over range when both apply.
  function automatic err_t decode_err(input logic [WORD_W-1:0] addr,
                                      input int unsigned addr_w);
    logic [WORD_W-1:0] hi;
    hi = addr >> (addr_w + 2);
    decode_err = ERR_NONE;
    if (hi != '0) decode_err = ERR_RANGE;
    if (addr[1:0] != 2'b00) decode_err = ERR_MISALIGN;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store port between the CPU datapath (master) and the data-memory
// responder (slave).
interface dm_responder_if;
  import dm_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [LANES-1:0]  be;
  logic [WORD_W-1:0] wdata;
  logic              ready;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rdata, err
  );

endinterface

// File: rtl/dm_array.sv
// Word storage for the responder: synchronous byte-enabled write, asynchronous
// read. Contents are deliberately not reset.
module dm_array
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [LANES-1:0]  wr_be,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_idx][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one word request at a time and completes it
// after WAIT wait states with a registered one-cycle ready pulse.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input logic           clk,
  input logic           reset,
  dm_responder_if.slave bus
);

  localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t            state;
  logic [3:0]        cnt;
  logic              l_we;
  logic [WORD_W-1:0] l_addr;
  logic [LANES-1:0]  l_be;
  logic [WORD_W-1:0] l_wdata;

  logic              accept;
  logic              go_resp;
  logic              op_we;
  logic [WORD_W-1:0] op_addr;
  logic [LANES-1:0]  op_be;
  logic [WORD_W-1:0] op_wdata;
  err_t              op_err;
  logic              op_ok;
  logic [WORD_W-1:0] mem_rd;

  // The operation finishing this edge comes from the latch when waiting in
  // BUSY, or straight from the bus when WAIT=0 completes on the accept edge.
  always_comb begin
    accept   = bus.req && (state != BUSY);
    go_resp  = (accept && (WAIT == 0)) || ((state == BUSY) && (cnt == 4'd0));
    op_we    = (state == BUSY) ? l_we    : bus.we;
    op_addr  = (state == BUSY) ? l_addr  : bus.addr;
    op_be    = (state == BUSY) ? l_be    : bus.be;
    op_wdata = (state == BUSY) ? l_wdata : bus.wdata;
    op_err   = decode_err(op_addr, ADDR_W);
    op_ok    = (op_err == ERR_NONE);
  end

  dm_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (go_resp && op_we && op_ok),
    .wr_idx  (op_addr[ADDR_W+1:2]),
    .wr_be   (op_be),
    .wr_data (op_wdata),
    .rd_idx  (op_addr[ADDR_W+1:2]),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      l_we      <= 1'b0;
      l_addr    <= '0;
      l_be      <= '0;
      l_wdata   <= '0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= go_resp;
      bus.err   <= go_resp && !op_ok;
      bus.rdata <= (go_resp && !op_we && op_ok) ? mem_rd : '0;
      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            l_we    <= bus.we;
            l_addr  <= bus.addr;
            l_be    <= bus.be;
            l_wdata <= bus.wdata;
            if (WAIT == 0) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: three instances (WAIT=2,0,3) against a
// cycle-count transaction model, plus directed literal checks.
module tb_dm_responder;

  localparam int ADDR_W = 10;
  localparam int W0 = 2;
  localparam int W1 = 0;
  localparam int W2 = 3;

  logic clk;
  logic reset;

  logic        req_d   [3];
  logic        we_d    [3];
  logic [31:0] addr_d  [3];
  logic [3:0]  be_d    [3];
  logic [31:0] wdata_d [3];
  logic        ready_q [3];
  logic        err_q   [3];
  logic [31:0] rdata_q [3];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? W0 : (g == 1) ? W1 : W2;
    dm_responder_if bus ();
    assign bus.req     = req_d[g];
    assign bus.we      = we_d[g];
    assign bus.addr    = addr_d[g];
    assign bus.be      = be_d[g];
    assign bus.wdata   = wdata_d[g];
    assign ready_q[g]  = bus.ready;
    assign err_q[g]    = bus.err;
    assign rdata_q[g]  = bus.rdata;
    dm_responder #(
      .ADDR_W (ADDR_W),
      .WAIT   (W)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  function automatic int waitOf(input int d);
    case (d)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Transaction model: a request is taken whenever nothing is outstanding and
  // completes exactly WAIT edges later, which is when memory is updated/read.
  int          cyc = 0;
  logic        m_pend  [3];
  int          m_done  [3];
  logic        m_we    [3];
  logic [31:0] m_addr  [3];
  logic [3:0]  m_be    [3];
  logic [31:0] m_wd    [3];
  logic        m_ready [3];
  logic        m_err   [3];
  logic        m_rdchk [3];
  logic [31:0] m_rdata [3];
  logic [31:0] mm [3][1024];

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_pend[d] = 0; m_ready[d] = 0; m_err[d] = 0; m_rdchk[d] = 1; m_rdata[d] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        m_ready[d] = 0; m_err[d] = 0; m_rdata[d] = 0; m_rdchk[d] = 1;
        if (!reset) begin
          m_pend[d] = 0;
        end else begin
          if (!m_pend[d] && req_d[d]) begin
            m_pend[d] = 1;
            m_done[d] = cyc + waitOf(d);
            m_we[d] = we_d[d]; m_addr[d] = addr_d[d]; m_be[d] = be_d[d]; m_wd[d] = wdata_d[d];
          end
          if (m_pend[d] && m_done[d] == cyc) begin
            logic bad;
            bad = (m_addr[d][1:0] != 2'b00) || (m_addr[d] >= (32'd1 << (ADDR_W + 2)));
            m_pend[d]  = 0;
            m_ready[d] = 1;
            m_err[d]   = bad;
            if (!bad && m_we[d]) begin
              m_rdchk[d] = 0;
              for (int l = 0; l < 4; l++)
                if (m_be[d][l]) mm[d][m_addr[d][11:2]][8*l +: 8] = m_wd[d][8*l +: 8];
            end
            if (!bad && !m_we[d]) m_rdata[d] = mm[d][m_addr[d][11:2]];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("dut%0d_ready@%0d", d, cyc), ready_q[d], m_ready[d]);
        checkOutput($sformatf("dut%0d_err@%0d", d, cyc), err_q[d], m_err[d]);
        if (m_rdchk[d])
          checkOutput($sformatf("dut%0d_rdata@%0d", d, cyc), rdata_q[d], m_rdata[d]);
      end
    end
  end

  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] wd,
                               output logic [31:0] rd, output logic e);
    int  n;
    logic got;
    nextCycle();
    req_d[d] = 1'b1; we_d[d] = w; addr_d[d] = a; be_d[d] = b; wdata_d[d] = wd;
    n = 0; got = 0; rd = 'x; e = 'x;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ready_q[d]) begin
        got = 1; rd = rdata_q[d]; e = err_q[d];
      end
    end
    #1;
    req_d[d] = 1'b0;
    checkOutput($sformatf("dut%0d_latency_%h", d, a), got ? n : -1, waitOf(d) + 1);
  endtask

  logic [31:0] rd;
  logic        e;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_d[d] = 0; we_d[d] = 0; addr_d[d] = 0; be_d[d] = 0; wdata_d[d] = 0;
    end
    repeat (3) nextCycle();
    checkOutput("reset_ready", ready_q[0], 0);
    checkOutput("reset_err", err_q[1], 0);
    checkOutput("reset_rdata", rdata_q[2], 0);
    reset = 1'b1;

    $display("[TB] write then read");
    applyStimulus(0, 1, 32'h10, 4'hF, 32'h12345678, rd, e);
    checkOutput("wr10_err", e, 0);
    applyStimulus(0, 0, 32'h10, 4'h0, 32'h0, rd, e);
    checkOutput("rd10_data", rd, 32'h12345678);
    checkOutput("rd10_err", e, 0);

    $display("[TB] byte enables");
    applyStimulus(0, 1, 32'h20, 4'hF, 32'hAABBCCDD, rd, e);
    applyStimulus(0, 1, 32'h20, 4'b0101, 32'h11223344, rd, e);
    applyStimulus(0, 0, 32'h20, 4'h0, 32'h0, rd, e);
    checkOutput("rd20_merged", rd, 32'hAA22CC44);

    $display("[TB] errors");
    applyStimulus(0, 1, 32'h0, 4'hF, 32'h55AA55AA, rd, e);
    applyStimulus(0, 0, 32'h13, 4'h0, 32'h0, rd, e);
    checkOutput("misalign_err", e, 1);
    checkOutput("misalign_rdata", rd, 0);
    applyStimulus(0, 1, 32'h1000, 4'hF, 32'hDEADBEEF, rd, e);
    checkOutput("range_err", e, 1);
    applyStimulus(0, 0, 32'h0, 4'h0, 32'h0, rd, e);
    checkOutput("rd0_unchanged", rd, 32'h55AA55AA);
    checkOutput("rd0_err", e, 0);

    $display("[TB] request during busy is ignored");
    begin
      int first, second;
      logic [31:0] r1, r2;
      first = -1; second = -1; r1 = 0; r2 = 0;
      nextCycle();
      req_d[0] = 1; we_d[0] = 0; addr_d[0] = 32'h10;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (ready_q[0]) begin
          if (first < 0) begin first = n; r1 = rdata_q[0]; end
          else if (second < 0) begin second = n; r2 = rdata_q[0]; end
        end
        #1;
        if (n == 1) addr_d[0] = 32'h20;
        if (second >= 0) req_d[0] = 0;
      end
      req_d[0] = 0;
      checkOutput("busy_first_cycle", first, 3);
      checkOutput("busy_second_cycle", second, 6);
      checkOutput("busy_first_data", r1, 32'h12345678);
      checkOutput("busy_second_data", r2, 32'hAA22CC44);
    end

    $display("[TB] back-to-back WAIT=0");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 32'(i * 4), 4'hF, 32'h10101010 * (i + 1), rd, e);
    nextCycle();
    req_d[1] = 1; we_d[1] = 0; addr_d[1] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_ready%0d", i), ready_q[1], 1);
      checkOutput($sformatf("b2b_data%0d", i), rdata_q[1], 32'h10101010 * (i + 1));
      #1;
      if (i < 3) addr_d[1] = 32'((i + 1) * 4);
      else       req_d[1] = 0;
    end
    @(negedge clk);
    checkOutput("b2b_end", ready_q[1], 0);

    $display("[TB] reset during busy");
    applyStimulus(2, 1, 32'h40, 4'hF, 32'h0BADF00D, rd, e);
    nextCycle();
    req_d[2] = 1; we_d[2] = 1; addr_d[2] = 32'h40; be_d[2] = 4'hF; wdata_d[2] = 32'hDEADBEEF;
    nextCycle();
    req_d[2] = 0;
    nextCycle();
    reset = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (ready_q[2]) pulses++;
        #1;
        if (i == 1) reset = 1'b1;
      end
      checkOutput("rst_no_ready", pulses, 0);
    end
    applyStimulus(2, 0, 32'h40, 4'h0, 32'h0, rd, e);
    checkOutput("rst_prior_data", rd, 32'h0BADF00D);
    checkOutput("rst_prior_err", e, 0);

    repeat (2) nextCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the MIPS core's load/store port. It accepts one word-aligned read or write request at a time and completes it after a fixed, parameterised number of wait states. It returns read data or an error flag with a single-cycle `ready` pulse. It sits between the CPU datapath (initiator) and the word storage, and replaces the zero-latency data memory so the core's stall logic can be exercised.

## Interface
- `ADDR_W`, default 10: log2 of memory depth in 32-bit words (1024 words = 4 KiB, byte addresses 0x0000–0x0FFF).
- `WAIT`, default 2: wait states inserted between acceptance and response (0–15).
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; `reset`=0 immediately forces the idle state.
- `req` in 1: request valid.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in 32: byte address; sampled with `req`.
- `be` in 4: byte enables for writes (bit i controls `wdata[8i+7:8i]`); ignored for reads.
- `wdata` in 32: write data; sampled with `req`.
- `ready` out 1: one-cycle completion pulse.
- `rdata` out 32: read word; valid only when `ready`=1 and `err`=0 on a read.
- `err` out 1: qualifies `ready`; 1 = request rejected.

## Operation
- FSM states: IDLE, BUSY, RESP. The state register and wait counter are reset to IDLE and 0.
- Acceptance:
  - A request is accepted on a rising edge when the state is IDLE or RESP and `req`=1.
  - On acceptance, `we`, `addr`, `be` and `wdata` are latched. The initiator may change them from the next cycle.
- Requests presented while in BUSY are ignored and are not queued. The initiator keeps `req` high until it sees `ready`.
- Transitions:
  - Accept with `WAIT`=0 goes to RESP.
  - Accept with `WAIT`>0 goes to BUSY, with the counter loaded to `WAIT`-1.
  - BUSY decrements the counter and goes to RESP when the counter is 0.
  - RESP goes to IDLE if there is no new request; otherwise the new request is accepted as above.
- Error check on the latched address:
  - `addr[1:0]`≠0 gives a misaligned error.
  - Any of `addr[31:ADDR_W+2]`≠0 gives an out-of-range error.
  - An erroring request never modifies memory, and `rdata` is 0.
- Writes:
  - A write commits on the edge that enters RESP.
  - Only the enabled bytes change. `be`=0000 is a legal no-op that still returns `ready`.
- Reads:
  - `rdata` reflects memory contents as of the edge entering RESP.
  - A read issued right after a write to the same word returns the new data.
- Reset:
  - Control outputs: `ready`=0, `err`=0, `rdata`=0.
  - Memory contents are not cleared.
  - Reset asserted during BUSY aborts the request; the pending write is discarded.

## Timing
- Latency: acceptance edge at cycle N gives `ready`=1 during cycle N+WAIT+1, for exactly one cycle.
- `ready`, `err` and `rdata` are registered outputs with no combinational path from the inputs.
- Throughput:
  - `WAIT`=0 with `req` held high gives `ready` on every cycle.
  - `WAIT`=k gives one completion per k+1 cycles.
- Outside RESP: `ready`=0, `err`=0, `rdata`=0.
- Reset deassertion is synchronised by the system. The first acceptance is possible on the first rising edge with `reset`=1.

## Structure
- Shared package `dm_pkg`:
  - state enum (IDLE/BUSY/RESP);
  - `WORD_W`=32;
  - byte-lane width 8;
  - the error-decode helper for alignment and range.
- Sub-module `dm_array`:
  - 2^ADDR_W × 32 storage;
  - synchronous byte-enabled write;
  - asynchronous read.
- FSM, counter, request latch and output registers live in `dm_responder`.

## Test plan
- Write then read (`WAIT`=2): write 0x12345678 to 0x0010 with `be`=1111, then read 0x0010 → `ready` 3 cycles after each acceptance, `rdata`=0x12345678, `err`=0.
- Byte enables: write 0xAABBCCDD to 0x0020 with `be`=1111, then 0x11223344 with `be`=0101, then read → 0xAA22CC44.
- Errors:
  - read from 0x0013 → `ready`=1, `err`=1, `rdata`=0;
  - write to 0x1000 → `err`=1, and a later read of 0x0000 is unchanged.
- Back-to-back (`WAIT`=0): hold `req` high for 4 reads of 0x0,0x4,0x8,0xC → `ready` high 4 consecutive cycles with the matching data.
- Reset mid-operation: accept a write of 0xDEADBEEF to 0x0040 (`WAIT`=3), pull `reset` low in cycle 2 → `ready` never pulses, and a later read of 0x0040 returns the prior contents.
- Ignored request: assert a second `req` while in BUSY → no extra `ready`; it is accepted only once RESP is reached.
